// File: rtl/dv_test_status_monitor.sv
// dv_test_status_monitor
// Snoops bus writes to the software test-status register, tracks the test
// phase (IDLE/BOOT/TEST/WFI/DONE), detects illegal status sequences and
// inactivity timeouts, and requests a single pass/fail banner from the
// consumer once the test has ended.
module dv_test_status_monitor #(
   parameter logic [31:0] StatusAddr    = 32'h0041_1000,
   parameter int unsigned TimeoutCycles = 1_000_000,
   parameter int unsigned CntWidth      = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                wr_valid_i,
   input  logic [31:0]         wr_addr_i,
   input  logic [31:0]         wr_data_i,
   input  logic                report_ack_i,
   output logic [2:0]          state_o,
   output logic                test_done_o,
   output logic                test_passed_o,
   output logic                timeout_o,
   output logic                protocol_err_o,
   output logic                report_req_o,
   output logic [CntWidth-1:0] status_cnt_o
);

   // Timeout counter only needs to reach TimeoutCycles-1.
   localparam int unsigned TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
   localparam logic [TW-1:0] TO_LIMIT = TW'(TimeoutCycles - 1);
   localparam logic [CntWidth-1:0] CNT_MAX = {CntWidth{1'b1}};

   // Software status codes (low half-word of the write data).
   localparam logic [15:0] CODE_BOOT    = 16'hb090;
   localparam logic [15:0] CODE_IN_TEST = 16'h4354;
   localparam logic [15:0] CODE_WFI     = 16'h1d1e;
   localparam logic [15:0] CODE_PASSED  = 16'h900d;
   localparam logic [15:0] CODE_FAILED  = 16'hbaad;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_BOOT = 3'd1,
      ST_TEST = 3'd2,
      ST_WFI  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // True for any of the five recognised status codes.
   function automatic logic is_known_code(input logic [15:0] code);
      logic known;
      case (code)
         CODE_BOOT, CODE_IN_TEST, CODE_WFI, CODE_PASSED, CODE_FAILED: known = 1'b1;
         default:                                                      known = 1'b0;
      endcase
      return known;
   endfunction

   // Registered state
   state_e                r_state;
   logic                  r_done;
   logic                  r_passed;
   logic                  r_timeout;
   logic                  r_perr;
   logic                  r_report_req;
   logic [TW-1:0]         r_to_cnt;
   logic [CntWidth-1:0]   r_status_cnt;

   // Combinational next-state values
   state_e                w_state_nxt;
   logic                  w_passed_nxt;
   logic                  w_timeout_nxt;
   logic                  w_perr_nxt;
   logic                  w_report_req_nxt;
   logic [TW-1:0]         w_to_cnt_nxt;
   logic [CntWidth-1:0]   w_status_cnt_nxt;

   logic                  w_decoded;
   logic                  w_active;
   logic                  w_expire;
   logic                  w_done_entry;
   logic [15:0]           w_code;
   logic                  w_unused_data;

   assign w_code        = wr_data_i[15:0];
   assign w_unused_data = ^wr_data_i[31:16];

   // Decode status writes and detect timeout expiry.
   always_comb begin
      w_active  = (r_state == ST_BOOT) || (r_state == ST_TEST) || (r_state == ST_WFI);
      // DONE is terminal: writes seen there are not decoded at all.
      w_decoded = wr_valid_i && (wr_addr_i == StatusAddr) && is_known_code(w_code)
                  && (r_state != ST_DONE);
      w_expire  = w_active && (r_to_cnt == TO_LIMIT);
   end

   // Next-state and sticky-flag logic; a decoded write beats timeout expiry.
   always_comb begin
      w_state_nxt   = r_state;
      w_passed_nxt  = r_passed;
      w_timeout_nxt = r_timeout;
      w_perr_nxt    = r_perr;
      if (w_decoded) begin
         case (r_state)
            ST_IDLE, ST_BOOT: begin
               if (w_code == CODE_BOOT) begin
                  w_state_nxt = ST_BOOT;
               end else if (w_code == CODE_IN_TEST) begin
                  w_state_nxt = ST_TEST;
               end else if (w_code == CODE_PASSED) begin
                  // Passing before the test ever started is not credible.
                  w_state_nxt  = ST_DONE;
                  w_passed_nxt = 1'b0;
                  w_perr_nxt   = 1'b1;
               end else if (w_code == CODE_FAILED) begin
                  w_state_nxt  = ST_DONE;
                  w_passed_nxt = 1'b0;
               end else if ((w_code == CODE_WFI) && (r_state == ST_BOOT)) begin
                  // WFI during boot is illegal; stay in BOOT.
                  w_perr_nxt = 1'b1;
               end else begin
                  w_state_nxt = r_state;
               end
            end
            ST_TEST, ST_WFI: begin
               if (w_code == CODE_IN_TEST) begin
                  w_state_nxt = ST_TEST;
               end else if (w_code == CODE_WFI) begin
                  w_state_nxt = ST_WFI;
               end else if (w_code == CODE_PASSED) begin
                  w_state_nxt  = ST_DONE;
                  w_passed_nxt = 1'b1;
               end else if (w_code == CODE_FAILED) begin
                  w_state_nxt  = ST_DONE;
                  w_passed_nxt = 1'b0;
               end else begin
                  w_state_nxt = r_state;
               end
            end
            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end else if (w_expire) begin
         w_state_nxt   = ST_DONE;
         w_timeout_nxt = 1'b1;
         w_passed_nxt  = 1'b0;
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Timeout counter, status-write counter and banner request next values.
   always_comb begin
      w_to_cnt_nxt     = r_to_cnt;
      w_status_cnt_nxt = r_status_cnt;
      w_report_req_nxt = r_report_req;
      w_done_entry     = (r_state != ST_DONE) && (w_state_nxt == ST_DONE);

      // Every decoded write (including BOOT entry) restarts the inactivity window.
      if (w_decoded) begin
         w_to_cnt_nxt = {TW{1'b0}};
      end else if (w_active && !w_expire) begin
         w_to_cnt_nxt = r_to_cnt + TW'(1);
      end else begin
         w_to_cnt_nxt = r_to_cnt;
      end

      if (w_decoded && (r_status_cnt != CNT_MAX)) begin
         w_status_cnt_nxt = r_status_cnt + CntWidth'(1);
      end else begin
         w_status_cnt_nxt = r_status_cnt;
      end

      // DONE is entered only once per reset, so the request can only rise once.
      if (w_done_entry) begin
         w_report_req_nxt = 1'b1;
      end else if (r_report_req && report_ack_i) begin
         w_report_req_nxt = 1'b0;
      end else begin
         w_report_req_nxt = r_report_req;
      end
   end

   // State register with asynchronous clear of every output and counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= ST_IDLE;
         r_done       <= 1'b0;
         r_passed     <= 1'b0;
         r_timeout    <= 1'b0;
         r_perr       <= 1'b0;
         r_report_req <= 1'b0;
         r_to_cnt     <= {TW{1'b0}};
         r_status_cnt <= {CntWidth{1'b0}};
      end else begin
         r_state      <= w_state_nxt;
         r_done       <= (w_state_nxt == ST_DONE);
         r_passed     <= w_passed_nxt;
         r_timeout    <= w_timeout_nxt;
         r_perr       <= w_perr_nxt;
         r_report_req <= w_report_req_nxt;
         r_to_cnt     <= w_to_cnt_nxt;
         r_status_cnt <= w_status_cnt_nxt;
      end
   end

   assign state_o        = r_state;
   assign test_done_o    = r_done;
   assign test_passed_o  = r_done & r_passed;
   assign timeout_o      = r_timeout;
   assign protocol_err_o = r_perr;
   assign report_req_o   = r_report_req;
   assign status_cnt_o   = r_status_cnt;

endmodule

// File: tb/tb_dv_test_status_monitor.sv
// Self-checking bench for dv_test_status_monitor: a table of single-cycle
// vectors plus hand-written timeout, race and saturation sequences. Expected
// outputs are queued when a vector is driven and compared after the edge.
module tb_dv_test_status_monitor;

   localparam logic [31:0] A   = 32'h0041_1000;
   localparam int unsigned TO  = 16;

   logic        clk_i;
   logic        rst_ni;
   logic        wr_valid_i;
   logic [31:0] wr_addr_i;
   logic [31:0] wr_data_i;
   logic        report_ack_i;
   logic [2:0]  state_o;
   logic        test_done_o;
   logic        test_passed_o;
   logic        timeout_o;
   logic        protocol_err_o;
   logic        report_req_o;
   logic [7:0]  status_cnt_o;

   dv_test_status_monitor #(
      .StatusAddr   (A),
      .TimeoutCycles(TO),
      .CntWidth     (8)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .wr_valid_i    (wr_valid_i),
      .wr_addr_i     (wr_addr_i),
      .wr_data_i     (wr_data_i),
      .report_ack_i  (report_ack_i),
      .state_o       (state_o),
      .test_done_o   (test_done_o),
      .test_passed_o (test_passed_o),
      .timeout_o     (timeout_o),
      .protocol_err_o(protocol_err_o),
      .report_req_o  (report_req_o),
      .status_cnt_o  (status_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic        is_rst;
      logic        valid;
      logic [31:0] addr;
      logic [15:0] data;
      logic        ack;
      logic [15:0] exp;
   } vec_t;

   vec_t        tbl[$];
   logic [15:0] exp_q[$];
   string       name_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   // Packed view: {state, done, passed, timeout, perr, req, cnt}
   function automatic logic [15:0] pk(input logic [2:0] st, input logic dn, input logic ps,
                                      input logic to, input logic pe, input logic rq,
                                      input logic [7:0] cnt);
      return {st, dn, ps, to, pe, rq, cnt};
   endfunction

   function automatic vec_t wv(input string name, input logic valid, input logic [31:0] addr,
                               input logic [15:0] data, input logic ack, input logic [15:0] exp);
      vec_t v;
      v.name = name; v.is_rst = 1'b0; v.valid = valid; v.addr = addr;
      v.data = data; v.ack = ack; v.exp = exp;
      return v;
   endfunction

   function automatic vec_t rv(input string name);
      vec_t v;
      v.name = name; v.is_rst = 1'b1; v.valid = 1'b0; v.addr = 32'h0;
      v.data = 16'h0; v.ack = 1'b0; v.exp = 16'h0000;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] exp);
      logic [15:0] act;
      act = {state_o, test_done_o, test_passed_o, timeout_o, protocol_err_o,
             report_req_o, status_cnt_o};
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got st=%0d dn=%b ps=%b to=%b pe=%b rq=%b cnt=%0d, expected st=%0d dn=%b ps=%b to=%b pe=%b rq=%b cnt=%0d",
                  name, act[15:13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                  exp[15:13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
      end
   endtask

   // Asynchronous reset pulse away from any clock edge; outputs must clear at once.
   task automatic pulse_reset(input string name);
      @(negedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      check(name, 16'h0000);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic apply(input string name, input logic valid, input logic [31:0] addr,
                        input logic [15:0] data, input logic ack, input logic [15:0] exp);
      @(negedge clk_i);
      wr_valid_i   = valid;
      wr_addr_i    = addr;
      wr_data_i    = {16'hdead, data};
      report_ack_i = ack;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clk_i);
      #1;
      wr_valid_i   = 1'b0;
      report_ack_i = 1'b0;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty, got no expectation", name);
      end else begin
         check(name_q.pop_front(), exp_q.pop_front());
      end
   endtask

   task automatic idle(input string name, input logic [15:0] exp);
      apply(name, 1'b0, A, 16'h0000, 1'b0, exp);
   endtask

   initial begin
      rst_ni       = 1'b0;
      wr_valid_i   = 1'b0;
      wr_addr_i    = 32'h0;
      wr_data_i    = 32'h0;
      report_ack_i = 1'b0;

      // Normal pass, banner handshake, DONE terminal
      tbl.push_back(rv("reset_initial"));
      tbl.push_back(wv("pass_boot",    1'b1, A, 16'hb090, 1'b0, pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1)));
      tbl.push_back(wv("pass_intest",  1'b1, A, 16'h4354, 1'b0, pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2)));
      tbl.push_back(wv("pass_done_ack_entry", 1'b1, A, 16'h900d, 1'b1, pk(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3)));
      tbl.push_back(wv("pass_req_hold", 1'b0, A, 16'h0000, 1'b0, pk(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3)));
      tbl.push_back(wv("pass_ack",     1'b0, A, 16'h0000, 1'b1, pk(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3)));
      tbl.push_back(wv("done_terminal", 1'b1, A, 16'hbaad, 1'b0, pk(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3)));
      tbl.push_back(wv("done_req_stays_low", 1'b0, A, 16'h0000, 1'b1, pk(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3)));
      // Early pass is a protocol error, then reset while DONE with req pending
      tbl.push_back(rv("reset_after_pass"));
      tbl.push_back(wv("early_boot",   1'b1, A, 16'hb090, 1'b0, pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1)));
      tbl.push_back(wv("early_pass",   1'b1, A, 16'h900d, 1'b0, pk(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2)));
      tbl.push_back(rv("reset_in_done"));
      // Address / code / strobe filtering, then WFI during BOOT and a FAILED end
      tbl.push_back(wv("filt_addr",    1'b1, A + 32'd4, 16'h900d, 1'b0, pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)));
      tbl.push_back(wv("filt_code",    1'b1, A, 16'h1234, 1'b0, pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)));
      tbl.push_back(wv("filt_strobe",  1'b0, A, 16'hb090, 1'b0, pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)));
      tbl.push_back(wv("ack_no_req",   1'b0, A, 16'h0000, 1'b1, pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)));
      tbl.push_back(wv("wfi_boot",     1'b1, A, 16'hb090, 1'b0, pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1)));
      tbl.push_back(wv("wfi_in_boot",  1'b1, A, 16'h1d1e, 1'b0, pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2)));
      tbl.push_back(wv("wfi_intest",   1'b1, A, 16'h4354, 1'b0, pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3)));
      tbl.push_back(wv("wfi_legal",    1'b1, A, 16'h1d1e, 1'b0, pk(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4)));
      tbl.push_back(wv("wfi_failed",   1'b1, A, 16'hbaad, 1'b0, pk(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5)));
      tbl.push_back(rv("reset_after_fail"));

      #12;
      check("reset_at_start", 16'h0000);
      foreach (tbl[i]) begin
         if (tbl[i].is_rst) begin
            pulse_reset(tbl[i].name);
         end else begin
            apply(tbl[i].name, tbl[i].valid, tbl[i].addr, tbl[i].data, tbl[i].ack, tbl[i].exp);
         end
      end

      // Timeout: DONE exactly TO cycles after the last decoded write
      apply("to_intest", 1'b1, A, 16'h4354, 1'b0, pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
      for (int k = 1; k < TO; k++) idle("to_wait", pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
      idle("to_expire", pk(3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1));
      idle("to_hold",   pk(3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1));
      pulse_reset("reset_after_timeout");

      // Race: a write on the expiry cycle wins and restarts the window
      apply("race_intest", 1'b1, A, 16'h4354, 1'b0, pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
      for (int k = 1; k < TO; k++) idle("race_wait", pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
      apply("race_write", 1'b1, A, 16'h4354, 1'b0, pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
      for (int k = 1; k < TO; k++) idle("race_rewait", pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
      idle("race_expire", pk(3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2));
      pulse_reset("reset_after_race");

      // Unknown code on the expiry cycle does not rescue the test
      apply("unk_intest", 1'b1, A, 16'h4354, 1'b0, pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
      for (int k = 1; k < TO; k++) idle("unk_wait", pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
      apply("unk_expire", 1'b1, A, 16'h1234, 1'b0, pk(3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1));
      pulse_reset("reset_after_unk");

      // Status counter saturates at all-ones
      for (int k = 1; k <= 260; k++) begin
         apply("sat_cnt", 1'b1, A, 16'h4354, 1'b0,
               pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (k > 255) ? 8'd255 : 8'(k)));
      end
      apply("sat_pass", 1'b1, A, 16'h900d, 1'b0, pk(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255));
      pulse_reset("reset_final");

      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
